// File: rtl/sobel_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_config_pkg
// Purpose  : Shared configuration for the streaming Sobel engine: default
//            frame geometry, the 3x3 Sobel kernels, the control FSM state
//            encoding and an absolute-value helper.
// Revision : 1.0  initial streaming release
// ============================================================================
package sobel_config_pkg;

  localparam int DEF_IMG_W      = 64;
  localparam int DEF_IMG_H      = 64;
  localparam int DEF_DATA_WIDTH = 8;

  // Kernels indexed [row][col]; row 0 is the top row, col 0 the left column.
  localparam logic signed [3:0] SOBEL_X [3][3] = '{
    '{-4'sd1, 4'sd0, 4'sd1},
    '{-4'sd2, 4'sd0, 4'sd2},
    '{-4'sd1, 4'sd0, 4'sd1}
  };

  localparam logic signed [3:0] SOBEL_Y [3][3] = '{
    '{-4'sd1, -4'sd2, -4'sd1},
    '{ 4'sd0,  4'sd0,  4'sd0},
    '{ 4'sd1,  4'sd2,  4'sd1}
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } sobel_state_e;

  // Absolute value on a 32-bit signed quantity; gradients here never get
  // near the 32-bit limits so the negation cannot overflow.
  function automatic int unsigned abs_int(input int v);
    return (v < 0) ? int'(-v) : int'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Purpose  : Circular shift buffer of DEPTH entries. Each shift writes data_i
//            and advances the pointer, so data_o is the value shifted in
//            exactly DEPTH shifts earlier (one image row of delay).
// Revision : 1.0  initial streaming release
// ============================================================================
module sobel_line_buffer #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;

  // The oldest entry sits at the pointer and is replaced by the shift.
  assign data_o = mem_q[ptr_q];

  // Pointer wrap at the last entry; depth need not be a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (shift_en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Storage is intentionally not reset; stale contents only feed borders.
  always_ff @(posedge clk_i) begin
    if (shift_en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream_engine
// Purpose  : Streams a grayscale frame from a synchronous-read RAM, forms a
//            3x3 window with two line buffers and writes the Sobel gradient
//            result for every pixel in raster order, one pixel per clock.
//            Border pixels are written as BORDER_VALUE.
// Options  : SOBEL_MAG_OUT_EN - when defined the output is the saturated
//            gradient magnitude instead of the thresholded binary edge map.
// Revision : 1.0  initial streaming release
// ============================================================================
module sobel_stream_engine
  import sobel_config_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = 12,
  parameter int BORDER_VALUE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH+3:0] threshold_i,
  output logic                  i_rd_en_o,
  output logic [ADDR_WIDTH-1:0] i_pixel_addr_o,
  input  logic [DATA_WIDTH-1:0] i_pixel_i,
  output logic                  o_wr_en_o,
  output logic [ADDR_WIDTH-1:0] o_pixel_addr_o,
  output logic [DATA_WIDTH-1:0] o_pixel_o,
  output logic                  busy_o,
  output logic                  finish_o
);

  localparam int NPIX      = IMG_W * IMG_H;
  localparam int SLOT_LAST = NPIX + IMG_W;          // last slot index of a frame
  localparam int SLOT_W    = $clog2(SLOT_LAST + 1);
  localparam int GW        = DATA_WIDTH + 3;        // signed gradient width
  localparam int MW        = DATA_WIDTH + 4;        // magnitude width
  localparam int XW        = $clog2(IMG_W);
  localparam int YW        = $clog2(IMG_H);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX    = '1;
  localparam logic [DATA_WIDTH-1:0] BORDER_PIX = DATA_WIDTH'(BORDER_VALUE);

  // ---------------------------------------------------------------- control
  sobel_state_e          state_q, state_d;
  logic [SLOT_W-1:0]     slot_q;
  logic                  accept;
  logic                  busy_q;
  logic                  cool_q;     // one-cycle hold-off after busy drops
  logic                  finish_q;

  // Next-state logic; a start is only taken once the previous frame has
  // fully drained and busy_o has been low for a cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !busy_q && !cool_q) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (slot_q == SLOT_W'(NPIX - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (slot_q == SLOT_W'(SLOT_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign i_rd_en_o      = (state_q == ST_READ);
  assign i_pixel_addr_o = (state_q == ST_READ) ? ADDR_WIDTH'(slot_q) : '0;
  assign busy_o         = busy_q;

  // State, slot counter, busy flag and the threshold captured at start.
`ifndef SOBEL_MAG_OUT_EN
  logic [MW-1:0] thr_q;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      cool_q  <= 1'b0;
`ifndef SOBEL_MAG_OUT_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cool_q  <= finish_q;
      if (accept) begin
        slot_q <= '0;
        busy_q <= 1'b1;
`ifndef SOBEL_MAG_OUT_EN
        thr_q  <= threshold_i;
`endif
      end else begin
        if (state_q != ST_IDLE) slot_q <= slot_q + SLOT_W'(1);
        if (finish_q)           busy_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------- stage 1: data slot
  logic s1_valid_q, s1_rd_q, s1_emit_q;

  // Slot bookkeeping delayed to line up with the returning RAM data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_emit_q  <= 1'b0;
    end else begin
      s1_valid_q <= (state_q != ST_IDLE);
      s1_rd_q    <= (state_q == ST_READ);
      s1_emit_q  <= (state_q != ST_IDLE) && (slot_q >= SLOT_W'(IMG_W + 1));
    end
  end

  logic [DATA_WIDTH-1:0] pix_in, lb1_out, lb2_out;
  assign pix_in = s1_rd_q ? i_pixel_i : '0;   // drain slots carry zero

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) u_lb_row1 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .shift_en_i (s1_valid_q),
    .data_i     (pix_in),
    .data_o     (lb1_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) u_lb_row2 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .shift_en_i (s1_valid_q),
    .data_i     (lb1_out),
    .data_o     (lb2_out)
  );

  // Two stored columns plus the incoming column form the 3x3 window.
  logic [DATA_WIDTH-1:0] win_q [3][2];
  logic [DATA_WIDTH-1:0] col_in [3];
  logic [DATA_WIDTH-1:0] win [3][3];

  // Incoming column: rows y-2, y-1, y top to bottom; window assembly.
  always_comb begin
    col_in[0] = lb2_out;
    col_in[1] = lb1_out;
    col_in[2] = pix_in;
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
      win[r][2] = col_in[r];
    end
  end

  // Window shifts left by one column on every slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (s1_valid_q) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= col_in[r];
      end
    end
  end

  // Kernel convolution over the assembled window.
  logic signed [GW-1:0] gx_d, gy_d;
  always_comb begin
    gx_d = '0;
    gy_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx_d = gx_d + GW'(SOBEL_X[r][c]) * GW'($signed({1'b0, win[r][c]}));
        gy_d = gy_d + GW'(SOBEL_Y[r][c]) * GW'($signed({1'b0, win[r][c]}));
      end
    end
  end

  // Centre position and output address of the slot currently emitting.
  logic [XW-1:0]         cx_q;
  logic [YW-1:0]         cy_q;
  logic [ADDR_WIDTH-1:0] ocnt_q;
  logic                  border_d;
  assign border_d = (cx_q == '0) || (cx_q == XW'(IMG_W - 1)) ||
                    (cy_q == '0) || (cy_q == YW'(IMG_H - 1));

  // Raster walk of the output centre, advanced once per emitting slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cx_q   <= '0;
      cy_q   <= '0;
      ocnt_q <= '0;
    end else if (accept) begin
      cx_q   <= '0;
      cy_q   <= '0;
      ocnt_q <= '0;
    end else if (s1_valid_q && s1_emit_q) begin
      ocnt_q <= ocnt_q + ADDR_WIDTH'(1);
      if (cx_q == XW'(IMG_W - 1)) begin
        cx_q <= '0;
        cy_q <= cy_q + YW'(1);
      end else begin
        cx_q <= cx_q + XW'(1);
      end
    end
  end

  // ------------------------------------------------- stage 2: gradients
  logic                  s2_valid_q, s2_border_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic signed [GW-1:0]  gx_q, gy_q;

  // Register the gradients alongside the centre's address and border flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q  <= 1'b0;
      s2_border_q <= 1'b0;
      s2_addr_q   <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
    end else begin
      s2_valid_q  <= s1_valid_q && s1_emit_q;
      s2_border_q <= border_d;
      s2_addr_q   <= ocnt_q;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
    end
  end

  logic [MW-1:0]         mag;
  logic [DATA_WIDTH-1:0] pix_d;

  // Magnitude and output pixel selection.
  always_comb begin
    mag   = MW'(abs_int(int'(gx_q)) + abs_int(int'(gy_q)));
    pix_d = BORDER_PIX;
    if (!s2_border_q) begin
`ifdef SOBEL_MAG_OUT_EN
      pix_d = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[DATA_WIDTH-1:0];
`else
      pix_d = (mag >= thr_q) ? PIX_MAX : '0;
`endif
    end
  end

  // ---------------------------------------------------- stage 3: output
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_pix_q;

  // Output register; the final address raises finish in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_pix_q  <= '0;
      finish_q  <= 1'b0;
    end else begin
      wr_en_q  <= s2_valid_q;
      finish_q <= s2_valid_q && (s2_addr_q == ADDR_WIDTH'(NPIX - 1));
      if (s2_valid_q) begin
        wr_addr_q <= s2_addr_q;
        wr_pix_q  <= pix_d;
      end
    end
  end

  assign o_wr_en_o      = wr_en_q;
  assign o_pixel_addr_o = wr_addr_q;
  assign o_pixel_o      = wr_pix_q;
  assign finish_o       = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_stream_engine
// Purpose  : Self-checking bench for sobel_stream_engine on an 8x8 frame with
//            an input RAM model and a pixel-level Sobel reference.
// Revision : 1.0  initial streaming release
// ============================================================================
module tb_sobel_stream_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int BV = 5;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [DW+3:0] threshold_i = '0;
  logic          i_rd_en_o;
  logic [AW-1:0] i_pixel_addr_o;
  logic [DW-1:0] i_pixel_i;
  logic          o_wr_en_o;
  logic [AW-1:0] o_pixel_addr_o;
  logic [DW-1:0] o_pixel_o;
  logic          busy_o;
  logic          finish_o;

  sobel_stream_engine #(
    .IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BORDER_VALUE(BV)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .threshold_i    (threshold_i),
    .i_rd_en_o      (i_rd_en_o),
    .i_pixel_addr_o (i_pixel_addr_o),
    .i_pixel_i      (i_pixel_i),
    .o_wr_en_o      (o_wr_en_o),
    .o_pixel_addr_o (o_pixel_addr_o),
    .o_pixel_o      (o_pixel_o),
    .busy_o         (busy_o),
    .finish_o       (finish_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_mem [N];
  int            exp_pix [N];
  int            out_mem [N];

  // Synchronous-read input RAM.
  always @(posedge clk) if (i_rd_en_o) i_pixel_i <= in_mem[i_pixel_addr_o];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic int px(input int x, input int y);
    return int'(in_mem[y*W + x]);
  endfunction

  function automatic int model_mag(input int x, input int y);
    int gx, gy;
    gx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
    gy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int model_out(input int x, input int y, input int thr);
    int m;
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return BV;
    m = model_mag(x, y);
`ifdef SOBEL_MAG_OUT_EN
    return (m > 255) ? 255 : m;
`else
    return (m >= thr) ? 255 : 0;
`endif
  endfunction

  // ------------------------------------------------------ output monitor
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, fin_cnt = 0;
  int rd9_cyc = 0, wr0_cyc = 0;
  bit prev_fin = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (prev_fin) check("busy_after_finish", busy_o, 0);
      prev_fin = finish_o;
      if (i_rd_en_o) begin
        check("rd_addr_order", i_pixel_addr_o, rd_cnt);
        if (int'(i_pixel_addr_o) == W+1) rd9_cyc = cyc;
        rd_cnt++;
      end
      if (o_wr_en_o) begin
        check("wr_addr_order", o_pixel_addr_o, wr_cnt);
        check("wr_data", o_pixel_o, exp_pix[o_pixel_addr_o]);
        out_mem[o_pixel_addr_o] = int'(o_pixel_o);
        if (wr_cnt == 0) wr0_cyc = cyc;
        wr_cnt++;
      end
      if (finish_o) begin
        fin_cnt++;
        check("finish_addr", o_pixel_addr_o, N-1);
        check("finish_with_write", o_wr_en_o, 1);
        check("busy_at_finish", busy_o, 1);
      end
    end else begin
      prev_fin = 1'b0;
    end
  end

  // ------------------------------------------------------ helpers
  task automatic prep(input int thr);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_pix[y*W + x] = model_out(x, y, thr);
    for (int i = 0; i < N; i++) out_mem[i] = -1;
    wr_cnt = 0; rd_cnt = 0; fin_cnt = 0;
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (fin_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (fin_cnt == 0) check("finish_timeout", 0, 1);
  endtask

  task automatic run_frame(input int thr);
    prep(thr);
    @(negedge clk);
    threshold_i = 12'(thr);
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
    threshold_i = 12'($urandom_range(0, 4095));   // must have been latched
    wait_finish();
    repeat (3) @(negedge clk);
    check("write_count", wr_cnt, N);
    check("read_count", rd_cnt, N);
    check("finish_count", fin_cnt, 1);
    check("first_write_latency", wr0_cyc - rd9_cyc, 3);
  endtask

  function automatic int count_255();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (out_mem[i] == 255) c++;
    return c;
  endfunction

  task automatic load_step(input bit vertical, input int amp);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        in_mem[y*W + x] = DW'(((vertical ? x : y) >= 4) ? amp : 0);
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    int n;
    #1;
    check("reset_wr_en", o_wr_en_o, 0);
    check("reset_rd_en", i_rd_en_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_finish", finish_o, 0);
    check("reset_pixel", o_pixel_o, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Constant image: every interior gradient is zero.
    for (int i = 0; i < N; i++) in_mem[i] = 8'd100;
    run_frame(1);
    check("const_interior", out_mem[3*W + 3], 0);
    check("const_border", out_mem[0], BV);

    // Vertical step 0 | 200.
    load_step(1'b1, 200);
    check("model_step_mag", model_mag(3, 4), 800);
    check("model_step_flat", model_mag(2, 4), 0);
    run_frame(400);
    check("step_col3", out_mem[2*W + 3], 255);
    check("step_col4", out_mem[5*W + 4], 255);
    check("step_col2", out_mem[2*W + 2], 0);
    check("step_border", out_mem[7*W + 4], BV);

    // Threshold boundary: 801 just misses, 800 just hits.
    run_frame(801);
`ifdef SOBEL_MAG_OUT_EN
    check("thr801_edges", count_255(), 12);
`else
    check("thr801_edges", count_255(), 0);
`endif
    run_frame(800);
    check("thr800_edges", count_255(), 12);

    // Horizontal step of amplitude 10.
    load_step(1'b0, 10);
    check("model_hstep_mag", model_mag(3, 3), 40);
    run_frame(40);
`ifdef SOBEL_MAG_OUT_EN
    check("hstep_row3", out_mem[3*W + 2], 40);
`else
    check("hstep_row3", out_mem[3*W + 2], 255);
`endif
    check("hstep_row2", out_mem[2*W + 2], 0);

    // Random images and thresholds.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) in_mem[i] = DW'($urandom_range(0, 255));
      run_frame(int'($urandom_range(0, 1100)));
    end

    // start held high for the whole frame: exactly one frame.
    for (int i = 0; i < N; i++) in_mem[i] = DW'($urandom_range(0, 255));
    prep(300);
    @(negedge clk);
    threshold_i = 12'd300;
    start_i     = 1'b1;
    wait_finish();
    start_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("held_start_idle", busy_o, 0);
    end
    check("held_start_writes", wr_cnt, N);
    check("held_start_finish", fin_cnt, 1);

    // Reset in the middle of a frame.
    for (int i = 0; i < N; i++) in_mem[i] = DW'($urandom_range(0, 255));
    prep(200);
    @(negedge clk);
    threshold_i = 12'd200;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (wr_cnt < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_write_20", wr_cnt >= 20, 1);
    rst_ni = 1'b0;
    #1;
    check("abort_wr_en", o_wr_en_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_rd_en", i_rd_en_o, 0);
    check("abort_pixel", o_pixel_o, 0);
    check("abort_addr", o_pixel_addr_o, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_write", o_wr_en_o, 0);
      check("abort_no_finish", finish_o, 0);
    end
    n = wr_cnt;
    rst_ni = 1'b1;
    repeat (120) @(negedge clk);
    check("abort_writes_stopped", wr_cnt, n);
    check("abort_finish_count", fin_cnt, 0);
    run_frame(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_stream_engine.md
# sobel_stream_engine

Parametrised, streaming successor to the single-pixel-window Sobel unit. It reads a grayscale frame from a synchronous-read image RAM at one pixel per clock and holds two image rows in line buffers. It computes the 3x3 Sobel gradient magnitude for every pixel and writes a same-size output frame in raster order at one pixel per clock, with explicit border handling. It sits between the input image memory and the output image memory in the edge-detector datapath.

## Interface
- IMG_W, default 64: frame width in pixels; minimum 4.
- IMG_H, default 64: frame height in pixels; minimum 4.
- DATA_WIDTH, default 8: pixel width.
- ADDR_WIDTH, default 12: memory address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.
- BORDER_VALUE, default 0: value written for border pixels.
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low (the one clock, the async active-low reset).
- start_i  in  1  level; begins a frame when sampled high in IDLE.
- threshold_i  in  DATA_WIDTH+4  edge threshold; sampled at the start handshake.
- i_rd_en_o  out  1  input RAM read strobe.
- i_pixel_addr_o  out  ADDR_WIDTH  input RAM read address.
- i_pixel_i  in  DATA_WIDTH  input RAM data, valid one cycle after the strobe.
- o_wr_en_o  out  1  output RAM write strobe.
- o_pixel_addr_o  out  ADDR_WIDTH  output RAM write address.
- o_pixel_o  out  DATA_WIDTH  output pixel.
- busy_o  out  1  high from the start handshake until finish.
- finish_o  out  1  one-cycle pulse on the final write.

## Operation
- FSM states: IDLE -> READ -> DRAIN -> IDLE.
- IDLE: when start_i=1, latch threshold_i, clear counters and go to READ. start_i is ignored outside IDLE.
- READ: issue i_rd_en_o=1 with addresses 0..N-1, where N=IMG_W*IMG_H, one per cycle. After address N-1, go to DRAIN.
- DRAIN: issue IMG_W+1 dummy pixel slots (value 0, no read strobe), then go to IDLE.
- Datapath counters track the (x,y) position of each arriving pixel. x wraps at IMG_W-1 and increments y.
- Two line buffers supply rows y-1 and y-2. A 3x3 window register shifts one column per slot.
- Each slot with input linear index k >= IMG_W+1 produces the output for centre c = k-(IMG_W+1) = (cx,cy).
- If cx=0, cx=IMG_W-1, cy=0 or cy=IMG_H-1, the output is BORDER_VALUE.
- Otherwise Gx and Gy use the kernels [-1 0 1; -2 0 2; -1 0 1] and [-1 -2 -1; 0 0 0; 1 2 1].
- Gx and Gy are signed, DATA_WIDTH+3 bits. mag = |Gx|+|Gy|, unsigned, DATA_WIDTH+4 bits, no overflow possible.
- Default output: (mag >= latched threshold) ? 2^DATA_WIDTH-1 : 0. Edges are white.
- Outputs are written to addresses 0..N-1 strictly in order, exactly N writes per frame.
- Dummy DRAIN pixels only ever feed border centres, so their value never reaches a computed output.

## Timing
- Read address at cycle t; data at t+1; Gx/Gy register at t+2; output register (o_wr_en_o, address, data) at t+3.
- First write occurs 3 cycles after the read of index IMG_W+1.
- Frame length is N+IMG_W+1 slots, plus a 3-cycle pipeline tail.
- finish_o and the write to address N-1 occur in the same cycle. busy_o falls in the following cycle.
- A new start_i is accepted no earlier than the cycle after busy_o falls.
- Reset values: every output is 0, the FSM is in IDLE, and the line buffers need not be cleared.
- A reset asserted mid-frame aborts immediately: no further writes, no finish_o.

## Configuration
- SOBEL_MAG_OUT_EN defined: o_pixel_o = min(mag, 2^DATA_WIDTH-1), a saturated magnitude. threshold_i is ignored.
- SOBEL_MAG_OUT_EN undefined: binary thresholded output as in Operation.

## Structure
- sobel_config_pkg holds:
  - default IMG_W, IMG_H, DATA_WIDTH;
  - the signed 4-bit SOBEL_X/SOBEL_Y kernel constants;
  - the FSM state enum typedef;
  - an abs-value function.
- Sub-module sobel_line_buffer: single-port circular shift buffer of depth IMG_W with one shift-enable. Two instances are cascaded.

## Test plan
- 8x8 constant image (all 100), threshold 1 -> 64 writes, addresses 0..63 in order; all outputs 0; finish_o on address 63.
- 8x8 vertical step (cols 0-3 = 0, cols 4-7 = 200), threshold 400 -> interior cols 3 and 4 = 255 (mag 800), other interior pixels 0, border = BORDER_VALUE.
- Same step image with SOBEL_MAG_OUT_EN -> interior cols 3 and 4 = 255 (saturated from 800); horizontal step of amplitude 10 -> 40.
- Step image run twice with threshold 801, then 800 -> first run has no 255 outputs; second run has 255 on cols 3 and 4.
- start_i held high throughout the frame -> exactly one frame; the next frame starts only after busy_o falls.
- rst_ni pulsed low at write 20 -> outputs 0 asynchronously, no more writes, no finish_o; a fresh start completes a full frame.
